// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with optional byte FIFO (define UART_TX_FIFO_EN to enable it).
// Latency: start bit appears one cycle after the accepting edge; each frame lasts 10*TICKS_PER_BIT cycles.
// Backpressure: bsy=1 while a byte is held or in flight (no FIFO) or while the FIFO is full; go is dropped then.

`ifdef UART_TX_FIFO_EN
// Circular FIFO with one extra pointer bit; flags are registered from next-state pointers.
module uart_tx_fifo_buf #(
   parameter int AW = 3,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push_vld,
   input  logic [DW-1:0] i_push_dat,
   input  logic          i_pop,
   output logic [DW-1:0] o_head_dat,
   output logic          o_full,
   output logic          o_empty
);
   logic [DW-1:0] r_mem [2**AW];
   logic [AW:0]   r_wp;
   logic [AW:0]   r_rp;
   logic [AW:0]   w_wp_nxt;
   logic [AW:0]   w_rp_nxt;
   logic          r_full;
   logic          r_empty;

   assign w_wp_nxt = r_wp + (AW+1)'(i_push_vld);
   assign w_rp_nxt = r_rp + (AW+1)'(i_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_wp    <= w_wp_nxt;
         r_rp    <= w_rp_nxt;
         r_full  <= (w_wp_nxt[AW] != w_rp_nxt[AW]) && (w_wp_nxt[AW-1:0] == w_rp_nxt[AW-1:0]);
         r_empty <= (w_wp_nxt == w_rp_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push_vld) begin
         r_mem[r_wp[AW-1:0]] <= i_push_dat;
      end
   end

   assign o_head_dat = r_mem[r_rp[AW-1:0]];
   assign o_full     = r_full;
   assign o_empty    = r_empty;
endmodule
`endif

module uart_tx_fifo #(
   parameter int CLK_FREQ        = 66_000_000,
   parameter int BAUD_RATE       = 9600,
   parameter int FIFO_DEPTH_LOG2 = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       go,
   output logic       bsy,
   output logic       idle,
   output logic       uart_tx
);
   localparam int TICKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int TW = (TICKS_PER_BIT < 2) ? 1 : $clog2(TICKS_PER_BIT);

   if (TICKS_PER_BIT < 2) begin : g_bad_ticks
      $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
   end
   if (FIFO_DEPTH_LOG2 < 1) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH_LOG2 must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_tick;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_nxt;
   logic          r_tx;
   logic          w_tx_nxt;
   logic          w_tick_end;
   logic          w_load;
   logic          w_pend;
   logic [7:0]    w_pend_dat;
   logic          w_accept;

   assign w_tick_end = (r_tick == TW'(TICKS_PER_BIT - 1));

`ifdef UART_TX_FIFO_EN
   logic w_full;
   logic w_empty;

   // A pop on the same edge frees a slot, so a push into a full FIFO is still taken.
   assign w_accept = go && (!w_full || w_load);

   uart_tx_fifo_buf #(
      .AW (FIFO_DEPTH_LOG2),
      .DW (8)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push_vld (w_accept),
      .i_push_dat (data),
      .i_pop      (w_load),
      .o_head_dat (w_pend_dat),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   assign w_pend = !w_empty;
   assign bsy    = w_full;
   assign idle   = (r_state == S_IDLE) && w_empty;
`else
   logic       r_hold_vld;
   logic [7:0] r_hold;

   assign w_accept = go && !bsy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_vld <= 1'b0;
         r_hold     <= '0;
      end else if (w_accept) begin
         r_hold_vld <= 1'b1;
         r_hold     <= data;
      end else if (w_load) begin
         r_hold_vld <= 1'b0;
      end
   end

   assign w_pend     = r_hold_vld;
   assign w_pend_dat = r_hold;
   assign bsy        = r_hold_vld || (r_state != S_IDLE);
   assign idle       = !bsy;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pend) begin
               w_state_nxt = S_START;
               w_load      = 1'b1;
            end
         end
         S_START: begin
            if (w_tick_end) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_tick_end && (r_bit == 3'd7)) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            // A pending byte restarts immediately so consecutive frames have no idle gap.
            if (w_tick_end) begin
               if (w_pend) begin
                  w_state_nxt = S_START;
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_shift_nxt = r_shift;
      w_tx_nxt    = 1'b1;
      if (w_load) begin
         w_shift_nxt = w_pend_dat;
      end else if ((r_state == S_DATA) && w_tick_end) begin
         w_shift_nxt = {1'b0, r_shift[7:1]};
      end
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         if ((r_state == S_IDLE) || w_tick_end) begin
            r_tick <= '0;
         end else begin
            r_tick <= r_tick + TW'(1);
         end
         if (r_state == S_START) begin
            r_bit <= '0;
         end else if ((r_state == S_DATA) && w_tick_end) begin
            r_bit <= r_bit + 3'd1;
         end
      end
   end

   assign uart_tx = r_tx;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: queue-based frame model plus an 8N1 line decoder.
module tb_uart_tx_fifo;
   localparam int CLK_FREQ  = 50_000_000;
   localparam int BAUD_RATE = 25_000_000;
   localparam int T         = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_FIFO_EN
   localparam int DEPTH = 8;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       go = 1'b0;
   logic [7:0] data = '0;
   logic       bsy;
   logic       idle;
   logic       uart_tx;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .CLK_FREQ        (CLK_FREQ),
      .BAUD_RATE       (BAUD_RATE),
      .FIFO_DEPTH_LOG2 (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .data    (data),
      .go      (go),
      .bsy     (bsy),
      .idle    (idle),
      .uart_tx (uart_tx)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: queue of accepted-but-unstarted bytes plus the frame on the wire.
   logic [7:0] q[$];
   logic [7:0] acc_q[$];
   bit         mbusy = 0;
   int         n = 0;
   int         fstart = 0;
   logic [7:0] fbyte = '0;
   logic       m_tx = 1'b1;
   logic       m_bsy = 1'b0;
   logic       m_idle = 1'b1;

   logic       line_q[$];
   int         rx_q[$];
   int         st_q[$];

   task automatic model_edge(input logic g, input logic [7:0] d, input logic r);
      logic prev_bsy;
      bit   ok;
      int   idx;
      n++;
      prev_bsy = m_bsy;
      if (r) begin
         q.delete();
         mbusy = 0;
      end else begin
         if (mbusy && (n - fstart) == 10 * T) mbusy = 0;
         if (!mbusy && q.size() > 0) begin
            fbyte  = q.pop_front();
            fstart = n;
            mbusy  = 1;
         end
`ifdef UART_TX_FIFO_EN
         ok = g && (q.size() < DEPTH);
`else
         ok = g && !prev_bsy;
`endif
         if (ok) begin
            q.push_back(d);
            acc_q.push_back(d);
         end
      end
      if (mbusy) begin
         idx = (n - fstart) / T;
         if (idx == 0) m_tx = 1'b0;
         else if (idx <= 8) m_tx = fbyte[idx-1];
         else m_tx = 1'b1;
      end else begin
         m_tx = 1'b1;
      end
`ifdef UART_TX_FIFO_EN
      m_bsy = (q.size() == DEPTH);
`else
      m_bsy = mbusy || (q.size() > 0);
`endif
      m_idle = !mbusy && (q.size() == 0);
   endtask

   task automatic tick(input logic g, input logic [7:0] d, input logic r);
      go   = g;
      data = d;
      rst  = r;
      @(posedge clk);
      model_edge(g, d, r);
      #1;
      line_q.push_back(uart_tx);
   endtask

   // Independent 8N1 receiver over the captured line samples (mid-bit sampling).
   task automatic decode_line();
      int         i;
      logic [7:0] b;
      rx_q.delete();
      st_q.delete();
      i = 0;
      while (i < line_q.size()) begin
         if (line_q[i] === 1'b0 && (i + 10 * T) <= line_q.size()) begin
            for (int k = 0; k < 8; k++) b[k] = line_q[i + (k + 1) * T + T / 2];
            st_q.push_back(i);
            if (line_q[i + T / 2] !== 1'b0 || line_q[i + 9 * T + T / 2] !== 1'b1) rx_q.push_back(-1);
            else rx_q.push_back(int'(b));
            i += 10 * T;
         end else begin
            i++;
         end
      end
   endtask

   task automatic test_reset();
      int hi;
      tick(1'b0, 8'h00, 1'b1);
      tick(1'b0, 8'h00, 1'b1);
      total += 3;
      if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
      if (bsy !== 1'b0) begin bad++; $display("FAIL reset_bsy got=%b exp=0", bsy); end
      if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 8'($urandom), 1'b0);
         if (uart_tx === 1'b1 && idle === 1'b1) hi++;
      end
      total++;
      if (hi !== 20) begin bad++; $display("FAIL reset_quiet got=%0d exp=20 idle-high cycles", hi); end
   endtask

   task automatic test_single_frame(input logic [7:0] b);
      line_q.delete();
      acc_q.delete();
      tick(1'b1, b, 1'b0);
      for (int i = 0; i < 26; i++) begin
         tick(1'b0, 8'($urandom), 1'b0);
         total += 3;
         if (uart_tx !== m_tx) begin bad++; $display("FAIL frame_tx byte=%h cyc=%0d got=%b exp=%b", b, i, uart_tx, m_tx); end
         if (bsy !== m_bsy) begin bad++; $display("FAIL frame_bsy byte=%h cyc=%0d got=%b exp=%b", b, i, bsy, m_bsy); end
         if (idle !== m_idle) begin bad++; $display("FAIL frame_idle byte=%h cyc=%0d got=%b exp=%b", b, i, idle, m_idle); end
      end
      decode_line();
      total += 2;
      if (rx_q.size() !== 1) begin bad++; $display("FAIL frame_count byte=%h got=%0d exp=1", b, rx_q.size()); end
      else if (rx_q[0] !== int'(b)) begin bad++; $display("FAIL frame_decode got=%0h exp=%h", rx_q[0], b); end
      if (st_q.size() > 0 && st_q[0] !== 1) begin bad++; $display("FAIL frame_latency got=%0d exp=1", st_q[0]); end
   endtask

   task automatic test_ignore_midframe();
      line_q.delete();
      acc_q.delete();
      tick(1'b1, 8'h3C, 1'b0);
      for (int i = 0; i < 36; i++) begin
         tick((i == 7), (i == 7) ? 8'hFF : 8'($urandom), 1'b0);
         total += 2;
         if (uart_tx !== m_tx) begin bad++; $display("FAIL mid_tx cyc=%0d got=%b exp=%b", i, uart_tx, m_tx); end
         if (bsy !== m_bsy) begin bad++; $display("FAIL mid_bsy cyc=%0d got=%b exp=%b", i, bsy, m_bsy); end
      end
      decode_line();
      total++;
      if (rx_q.size() !== acc_q.size()) begin bad++; $display("FAIL mid_count got=%0d exp=%0d", rx_q.size(), acc_q.size()); end
`ifndef UART_TX_FIFO_EN
      total++;
      if (rx_q.size() !== 1 || rx_q[0] !== 32'h3C) begin bad++; $display("FAIL mid_ignored frames=%0d exp=1 of 3c", rx_q.size()); end
`endif
   endtask

   task automatic test_reset_midframe();
      tick(1'b1, 8'h99, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b0);
      tick(1'b0, 8'h00, 1'b1);
      total += 3;
      if (uart_tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b exp=1", uart_tx); end
      if (bsy !== 1'b0) begin bad++; $display("FAIL rstmid_bsy got=%b exp=0", bsy); end
      if (idle !== 1'b1) begin bad++; $display("FAIL rstmid_idle got=%b exp=1", idle); end
      test_single_frame(8'h0F);
   endtask

   task automatic test_random();
      line_q.delete();
      acc_q.delete();
      for (int i = 0; i < 820; i++) begin
         tick((i < 600) && ($urandom_range(5) == 0), 8'($urandom), 1'b0);
         total += 3;
         if (uart_tx !== m_tx) begin bad++; $display("FAIL rand_tx cyc=%0d got=%b exp=%b", i, uart_tx, m_tx); end
         if (bsy !== m_bsy) begin bad++; $display("FAIL rand_bsy cyc=%0d got=%b exp=%b", i, bsy, m_bsy); end
         if (idle !== m_idle) begin bad++; $display("FAIL rand_idle cyc=%0d got=%b exp=%b", i, idle, m_idle); end
      end
      decode_line();
      total++;
      if (rx_q.size() !== acc_q.size()) begin
         bad++; $display("FAIL rand_count got=%0d exp=%0d", rx_q.size(), acc_q.size());
      end else begin
         for (int i = 0; i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== int'(acc_q[i])) begin bad++; $display("FAIL rand_byte idx=%0d got=%0h exp=%h", i, rx_q[i], acc_q[i]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      line_q.delete();
      acc_q.delete();
`ifdef UART_TX_FIFO_EN
      for (int k = 1; k <= 8; k++) begin
         tick(1'b1, 8'(k), 1'b0);
         total++;
         if (bsy !== m_bsy) begin bad++; $display("FAIL b2b_bsy push=%0d got=%b exp=%b", k, bsy, m_bsy); end
      end
      tick(1'b1, 8'h09, 1'b0);
      total++;
      if (bsy !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b exp=1", bsy); end
      tick(1'b1, 8'h0A, 1'b0);
      total++;
      if (bsy !== 1'b1) begin bad++; $display("FAIL b2b_still_full got=%b exp=1", bsy); end
      for (int i = 0; i < 200; i++) begin
         tick(1'b0, 8'($urandom), 1'b0);
         total += 2;
         if (uart_tx !== m_tx) begin bad++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", i, uart_tx, m_tx); end
         if (bsy !== m_bsy) begin bad++; $display("FAIL b2b_bsy cyc=%0d got=%b exp=%b", i, bsy, m_bsy); end
      end
      decode_line();
      total++;
      if (rx_q.size() !== 9) begin
         bad++; $display("FAIL b2b_count got=%0d exp=9", rx_q.size());
      end else begin
         for (int k = 0; k < 9; k++) begin
            total += 2;
            if (rx_q[k] !== k + 1) begin bad++; $display("FAIL b2b_byte idx=%0d got=%0h exp=%0h", k, rx_q[k], k + 1); end
            if (k > 0 && st_q[k] - st_q[k-1] !== 10 * T) begin bad++; $display("FAIL b2b_gap idx=%0d got=%0d exp=%0d", k, st_q[k] - st_q[k-1], 10 * T); end
         end
      end
`else
      tick(1'b1, 8'h11, 1'b0);
      tick(1'b1, 8'h22, 1'b0);
      total++;
      if (bsy !== 1'b1) begin bad++; $display("FAIL b2b_bsy got=%b exp=1", bsy); end
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 8'($urandom), 1'b0);
         total++;
         if (uart_tx !== m_tx) begin bad++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", i, uart_tx, m_tx); end
      end
      decode_line();
      total++;
      if (rx_q.size() !== 1 || rx_q[0] !== 32'h11) begin bad++; $display("FAIL b2b_drop frames=%0d exp=1 of 11", rx_q.size()); end
`endif
   endtask

   initial begin
      test_reset();
      test_single_frame(8'h55);
      test_single_frame(8'hA3);
      test_ignore_midframe();
      test_reset_midframe();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
